// File: rtl/sd_init_pkg.sv
// Shared SD command constants, R1/OCR bit positions and response checks
// used by the card initialization sequencer.
package sd_init_pkg;

    localparam logic [5:0] CMD2  = 6'd2;
    localparam logic [5:0] CMD3  = 6'd3;
    localparam logic [5:0] CMD6  = 6'd6;
    localparam logic [5:0] CMD7  = 6'd7;
    localparam logic [5:0] CMD8  = 6'd8;
    localparam logic [5:0] CMD41 = 6'd41;
    localparam logic [5:0] CMD55 = 6'd55;

    localparam logic [11:0] CMD8_CHECK = 12'h1AA;
    localparam logic [31:0] CMD8_ARG   = {20'h0, CMD8_CHECK};
    localparam logic [31:0] ACMD41_ARG = 32'h40FF_8000;
    localparam logic [31:0] ACMD6_ARG  = 32'h0000_0002;

    localparam int R1_OUT_OF_RANGE = 31;
    localparam int R1_ADDR_ERROR   = 30;
    localparam int R1_ILLEGAL_CMD  = 22;
    localparam int R1_CARD_ERROR   = 19;
    localparam int R1_APP_CMD      = 5;

    // OCR bit 31 is the power-up-complete flag (low while the card is busy)
    localparam int OCR_READY = 31;
    localparam int OCR_CCS   = 30;

    typedef enum logic [3:0] {
        S_IDLE, S_PWRUP, S_CMD8, S_CMD55, S_ACMD41, S_CMD2, S_GAP,
        S_CMD3, S_CMD7, S_CMD55B, S_ACMD6, S_DONE, S_ERR
    } state_t;

    function automatic logic r1_ok(input logic [31:0] resp, input logic need_app);
        return !(resp[R1_OUT_OF_RANGE] | resp[R1_ADDR_ERROR] |
                 resp[R1_ILLEGAL_CMD]  | resp[R1_CARD_ERROR]) &&
               (!need_app || resp[R1_APP_CMD]);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sd_init.sv
// SD card initialization sequencer: walks CMD8/ACMD41/CMD2/CMD3/CMD7/ACMD6
// through an external command driver, latching RCA and capacity status.
module sd_init
    import sd_init_pkg::*;
#(
    parameter int PWRUP_CYC = 80,
    parameter int TIMEOUT   = 4096,
    parameter int RETRIES   = 1000,
    parameter int GAP_CYC   = 128
) (
    input  logic        iclk,
    input  logic        irst,
    input  logic        istart,
    input  logic [31:0] iresp,
    input  logic        idone,
    output logic        ostart,
    output logic [5:0]  ocmd_index,
    output logic [31:0] ocmd_arg,
    output logic [15:0] orca,
    output logic        occs,
    output logic        odone,
    output logic        oerr
);

    localparam int CNT_W = $clog2(max3(PWRUP_CYC, TIMEOUT, GAP_CYC) + 1);
    localparam int TRY_W = $clog2(RETRIES + 1);

    localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [TRY_W-1:0] TRY_LAST   = TRY_W'(RETRIES - 1);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [TRY_W-1:0]  tries, tries_n;
    logic              ostart_n, ccs_n;
    logic [5:0]        idx_n, sel_idx;
    logic [31:0]       arg_n, sel_arg;
    logic [15:0]       rca_n;

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            tries      <= '0;
            ostart     <= 1'b0;
            ocmd_index <= '0;
            ocmd_arg   <= '0;
            orca       <= '0;
            occs       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            tries      <= tries_n;
            ostart     <= ostart_n;
            ocmd_index <= idx_n;
            ocmd_arg   <= arg_n;
            orca       <= rca_n;
            occs       <= ccs_n;
        end
    end

    always_comb begin
        sel_idx = '0;
        sel_arg = '0;
        case (state)
            S_CMD8:   begin sel_idx = CMD8;  sel_arg = CMD8_ARG;       end
            S_CMD55:  begin sel_idx = CMD55; sel_arg = '0;             end
            S_ACMD41: begin sel_idx = CMD41; sel_arg = ACMD41_ARG;     end
            S_CMD2:   begin sel_idx = CMD2;  sel_arg = '0;             end
            S_CMD3:   begin sel_idx = CMD3;  sel_arg = '0;             end
            S_CMD7:   begin sel_idx = CMD7;  sel_arg = {orca, 16'h0};  end
            S_CMD55B: begin sel_idx = CMD55; sel_arg = {orca, 16'h0};  end
            S_ACMD6:  begin sel_idx = CMD6;  sel_arg = ACMD6_ARG;      end
            default:  ;
        endcase
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        tries_n  = tries;
        ostart_n = ostart;
        idx_n    = ocmd_index;
        arg_n    = ocmd_arg;
        rca_n    = orca;
        ccs_n    = occs;
        case (state)
            S_IDLE: if (istart) begin
                state_n = S_PWRUP;
                cnt_n   = '0;
            end
            S_PWRUP: if (cnt == PWRUP_LAST) begin
                state_n = S_CMD8;
                cnt_n   = '0;
            end else cnt_n = cnt + 1'b1;
            S_GAP: if (cnt == GAP_LAST) begin
                state_n = S_CMD3;
                cnt_n   = '0;
            end else cnt_n = cnt + 1'b1;
            S_DONE, S_ERR: ;
            default: begin
                // Command states: issue, then wait for idone or the timeout.
                // Leaving the state drops ostart, which gives the mandatory
                // low cycle before the next command is raised.
                if (!ostart) begin
                    ostart_n = 1'b1;
                    idx_n    = sel_idx;
                    arg_n    = sel_arg;
                    cnt_n    = '0;
                end else if (idone) begin
                    ostart_n = 1'b0;
                    cnt_n    = '0;
                    case (state)
                        S_CMD8:   state_n = (iresp[11:0] == CMD8_CHECK) ? S_CMD55 : S_ERR;
                        S_CMD55:  state_n = r1_ok(iresp, 1'b1) ? S_ACMD41 : S_ERR;
                        S_ACMD41: if (iresp[OCR_READY]) begin
                            ccs_n   = iresp[OCR_CCS];
                            state_n = S_CMD2;
                        end else if (tries == TRY_LAST) begin
                            state_n = S_ERR;
                        end else begin
                            tries_n = tries + 1'b1;
                            state_n = S_CMD55;
                        end
                        S_CMD2:   state_n = S_GAP;
                        S_CMD3: begin
                            rca_n   = iresp[31:16];
                            state_n = S_CMD7;
                        end
                        S_CMD7:   state_n = r1_ok(iresp, 1'b0) ? S_CMD55B : S_ERR;
                        S_CMD55B: state_n = r1_ok(iresp, 1'b1) ? S_ACMD6 : S_ERR;
                        S_ACMD6:  state_n = r1_ok(iresp, 1'b0) ? S_DONE : S_ERR;
                        default:  ;
                    endcase
                end else if (cnt == TO_LAST) begin
                    ostart_n = 1'b0;
                    state_n  = S_ERR;
                end else cnt_n = cnt + 1'b1;
            end
        endcase
    end

    assign odone = (state == S_DONE);
    assign oerr  = (state == S_ERR);

endmodule

// File: tb/tb_sd_init.sv
// Self-checking bench for sd_init: behavioural cmd_driver with scripted
// responses, plus a procedural model of the init sequence rules.
module tb_sd_init;

    localparam int PWRUP_CYC = 20;
    localparam int TIMEOUT   = 200;
    localparam int RETRIES   = 4;
    localparam int GAP_CYC   = 16;
    localparam int LAT       = 100;

    logic        iclk, irst, istart, idone;
    logic [31:0] iresp;
    logic        ostart, occs, odone, oerr;
    logic [5:0]  ocmd_index;
    logic [31:0] ocmd_arg;
    logic [15:0] orca;

    sd_init #(
        .PWRUP_CYC(PWRUP_CYC), .TIMEOUT(TIMEOUT), .RETRIES(RETRIES), .GAP_CYC(GAP_CYC)
    ) dut (
        .iclk(iclk), .irst(irst), .istart(istart), .iresp(iresp), .idone(idone),
        .ostart(ostart), .ocmd_index(ocmd_index), .ocmd_arg(ocmd_arg),
        .orca(orca), .occs(occs), .odone(odone), .oerr(oerr)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // script entry: bit 32 set means the driver never answers that command
    logic [32:0] script[$];
    int          drv_k;
    bit          drv_busy;
    int          drv_cnt;
    logic [32:0] cur;
    logic [5:0]  cur_idx;
    logic [31:0] cur_arg;
    logic [5:0]  rec_idx[$];
    logic [31:0] rec_arg[$];
    int          first_rise, last_rise, stab_err;

    logic [5:0]  exp_idx[$];
    logic [31:0] exp_arg[$];
    bit          exp_done;
    logic [15:0] exp_rca;
    logic        exp_ccs;
    int          mk;
    int          end_cyc, c_start;

    initial begin
        iclk = 1'b0;
        forever #5 iclk = ~iclk;
    end

    initial forever begin
        @(posedge iclk);
        cyc++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Behavioural cmd_driver: answers each ostart after LAT cycles from the script
    initial begin : drv
        idone    = 1'b0;
        iresp    = '0;
        drv_busy = 1'b0;
        forever begin
            @(negedge iclk);
            idone = 1'b0;
            if (irst || (drv_busy && !ostart)) begin
                drv_busy = 1'b0;
            end else if (drv_busy) begin
                if (ocmd_index !== cur_idx || ocmd_arg !== cur_arg) stab_err++;
                drv_cnt++;
                if (drv_cnt == LAT && !cur[32]) begin
                    idone    = 1'b1;
                    iresp    = cur[31:0];
                    drv_busy = 1'b0;
                end
            end else if (ostart) begin
                cur_idx = ocmd_index;
                cur_arg = ocmd_arg;
                if (rec_idx.size() == 0) first_rise = cyc;
                last_rise = cyc;
                rec_idx.push_back(ocmd_index);
                rec_arg.push_back(ocmd_arg);
                cur = (drv_k < script.size()) ? script[drv_k] : {1'b1, 32'h0};
                drv_k++;
                drv_busy = 1'b1;
                drv_cnt  = 0;
            end else if ($urandom_range(0, 7) == 0) begin
                // stray completion while no command is outstanding
                idone = 1'b1;
                iresp = $urandom;
            end
        end
    end

    function automatic bit r1_good(input logic [31:0] r, input bit app);
        return ((r & 32'hC048_0000) == 32'h0) && (!app || r[5]);
    endfunction

    task automatic take(input logic [5:0] idx, input logic [31:0] arg,
                        output logic [31:0] r, output bit ans);
        exp_idx.push_back(idx);
        exp_arg.push_back(arg);
        ans = (mk < script.size()) && !script[mk][32];
        r   = (mk < script.size()) ? script[mk][31:0] : 32'h0;
        mk++;
    endtask

    // Reference: walk the init sequence over the script, stopping at the first failure
    task automatic predict();
        logic [31:0] r;
        bit          ans, rdy;
        exp_idx.delete(); exp_arg.delete();
        exp_done = 0; exp_rca = '0; exp_ccs = 1'b0; mk = 0;
        take(6'd8, 32'h0000_01AA, r, ans);
        if (!ans || r[11:0] != 12'h1AA) return;
        rdy = 0;
        for (int t = 0; t < RETRIES && !rdy; t++) begin
            take(6'd55, 32'h0, r, ans);
            if (!ans || !r1_good(r, 1)) return;
            take(6'd41, 32'h40FF_8000, r, ans);
            if (!ans) return;
            if (r[31]) begin rdy = 1; exp_ccs = r[30]; end
        end
        if (!rdy) return;
        take(6'd2, 32'h0, r, ans);
        if (!ans) return;
        take(6'd3, 32'h0, r, ans);
        if (!ans) return;
        exp_rca = r[31:16];
        take(6'd7, {exp_rca, 16'h0}, r, ans);
        if (!ans || !r1_good(r, 0)) return;
        take(6'd55, {exp_rca, 16'h0}, r, ans);
        if (!ans || !r1_good(r, 1)) return;
        take(6'd6, 32'h2, r, ans);
        if (!ans || !r1_good(r, 0)) return;
        exp_done = 1;
    endtask

    task automatic push(input logic [31:0] v);
        script.push_back({1'b0, v});
    endtask

    function automatic logic [31:0] rand_r1(input bit app);
        logic [31:0] v;
        v = $urandom & ~32'hC048_0000;
        if (app) v[5] = 1'b1;
        if ($urandom_range(0, 11) == 0) begin
            case ($urandom_range(0, 4))
                0: v[31] = 1'b1;
                1: v[30] = 1'b1;
                2: v[22] = 1'b1;
                3: v[19] = 1'b1;
                default: v[5] = 1'b0;
            endcase
        end
        return v;
    endfunction

    task automatic gen_random();
        logic [31:0] v;
        int b, bit_i;
        script.delete();
        v = $urandom;
        v[11:0] = 12'h1AA;
        if ($urandom_range(0, 9) == 0) begin
            bit_i = $urandom_range(0, 11);
            v[bit_i] = ~v[bit_i];
        end
        push(v);
        b = $urandom_range(0, RETRIES);
        for (int i = 0; i <= b && i < RETRIES; i++) begin
            push(rand_r1(1));
            v = $urandom;
            v[31] = (i < b) ? 1'b0 : 1'b1;
            push(v);
        end
        push($urandom);
        push($urandom);
        push(rand_r1(0));
        push(rand_r1(1));
        push(rand_r1(0));
    endtask

    task automatic busy_script(input int nbusy);
        script.delete();
        push(32'h0000_01AA);
        for (int i = 0; i < nbusy; i++) begin push(32'h0000_0120); push(32'h00FF_8000); end
        push(32'h0000_0120); push(32'h80FF_8000);
        push(32'h0);         push(32'hABCD_0500);
        push(32'h0);         push(32'h0000_0120); push(32'h0);
    endtask

    task automatic do_reset(input string name);
        irst = 1'b1;
        istart = 1'b0;
        repeat (2) @(negedge iclk);
        chk({name, " reset values"},
            {ostart, odone, oerr, occs, ocmd_index, ocmd_arg, orca}, 64'h0);
        irst = 1'b0;
    endtask

    task automatic run_scenario(input string name);
        int n;
        logic [37:0] got;
        predict();
        rec_idx.delete(); rec_arg.delete();
        drv_k = 0; stab_err = 0;
        @(negedge iclk);
        istart = 1'b1;
        c_start = cyc;
        @(negedge iclk);
        istart = 1'b0;
        n = 0;
        while (!(odone || oerr) && n < 3000) begin @(negedge iclk); n++; end
        end_cyc = cyc;
        chk({name, " finished"}, odone | oerr, 1);
        // terminal states must ignore a fresh istart and issue nothing more
        repeat (20) @(negedge iclk);
        istart = 1'b1;
        @(negedge iclk);
        istart = 1'b0;
        repeat (LAT + 50) @(negedge iclk);
        chk({name, " cmd count"}, rec_idx.size(), exp_idx.size());
        for (int i = 0; i < exp_idx.size(); i++) begin
            got = (i < rec_idx.size()) ? {rec_idx[i], rec_arg[i]} : 38'h3F_FFFF_FFFF;
            chk($sformatf("%s cmd%0d idx/arg", name, i), got, {exp_idx[i], exp_arg[i]});
        end
        chk({name, " pwrup latency"}, (rec_idx.size() > 0) ? first_rise - c_start : -1,
            PWRUP_CYC + 2);
        chk({name, " odone"}, odone, exp_done);
        chk({name, " oerr"}, oerr, !exp_done);
        chk({name, " orca"}, orca, exp_rca);
        chk({name, " occs"}, occs, exp_ccs);
        chk({name, " cmd stable"}, stab_err, 0);
        chk({name, " ostart idle"}, ostart, 0);
        chk({name, " done/err exclusive"}, odone & oerr, 0);
    endtask

    initial begin : main
        int n;
        irst = 1'b1;
        istart = 1'b0;
        drv_k = 0;

        do_reset("happy");
        script.delete();
        push(32'h0000_01AA); push(32'h0000_0120); push(32'hC0FF_8000);
        push($urandom);      push(32'h1234_0500); push(32'h0);
        push(32'h0000_0120); push(32'h0);
        run_scenario("happy");
        chk("happy orca const", orca, 16'h1234);
        chk("happy occs const", occs, 1);

        do_reset("busy");
        busy_script(2);
        script[2][31:0] = 32'h00FF_8000;
        script[6][31:0] = 32'h80FF_8000;
        run_scenario("busy");
        chk("busy occs const", occs, 0);

        do_reset("cmd8_bad");
        script.delete();
        push(32'h0000_01AB);
        run_scenario("cmd8_bad");

        do_reset("retries");
        busy_script(RETRIES);
        run_scenario("retries");

        do_reset("cmd55_err");
        script.delete();
        push(32'h0000_01AA); push(32'h0040_0120);
        run_scenario("cmd55_err");

        do_reset("timeout");
        script.delete();
        push(32'h0000_01AA); push(32'h0000_0120); push(32'hC0FF_8000); push(32'h0);
        script.push_back({1'b1, 32'h0});
        run_scenario("timeout");
        chk("timeout exact cycles", end_cyc - last_rise, TIMEOUT);

        do_reset("midreset");
        busy_script(3);
        rec_idx.delete(); rec_arg.delete();
        drv_k = 0;
        @(negedge iclk);
        istart = 1'b1;
        @(negedge iclk);
        istart = 1'b0;
        n = 0;
        while (rec_idx.size() < 6 && n < 3000) begin @(negedge iclk); n++; end
        chk("midreset reached third CMD55", rec_idx.size() >= 6, 1);
        repeat (40) @(negedge iclk);
        #2 irst = 1'b1;
        #1 chk("midreset async outputs",
               {ostart, odone, oerr, occs, ocmd_index, ocmd_arg, orca}, 64'h0);
        @(negedge iclk);
        irst = 1'b0;
        run_scenario("rerun");

        for (int s = 0; s < 6; s++) begin
            do_reset($sformatf("rand%0d", s));
            gen_random();
            run_scenario($sformatf("rand%0d", s));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_init.md
SD_INIT -- requirements
Module: sd_init

Interface
REQ-001 Parameter PWRUP_CYC, default 80: idle cycles before the first command (>=74 card init clocks).
REQ-002 Parameter TIMEOUT, default 4096: cycles allowed from ostart rise to idone.
REQ-003 Parameter RETRIES, default 1000: maximum ACMD41 attempts.
REQ-004 Parameter GAP_CYC, default 128: quiet cycles after CMD2 completion.
REQ-005 iclk  in  1  clock; single clock domain.
REQ-006 irst  in  1  asynchronous, active-high reset.
REQ-007 istart  in  1  begin initialization; sampled in IDLE only.
REQ-008 iresp  in  32  response argument from cmd_driver (R1/R3/R6/R7 bits [39:8]).
REQ-009 idone  in  1  cmd_driver completion; response valid on iresp in that cycle.
REQ-010 ostart  out  1  command request to cmd_driver.
REQ-011 ocmd_index  out  6  command index.
REQ-012 ocmd_arg  out  32  command argument.
REQ-013 orca  out  16  card RCA from CMD3.
REQ-014 occs  out  1  card capacity status (ACMD41 resp[30]).
REQ-015 odone  out  1  initialization complete, level.
REQ-016 oerr  out  1  initialization failed, level.

Function
REQ-017 Sequence: IDLE -> PWRUP -> CMD8 -> CMD55 -> ACMD41 -> CMD2 -> GAP -> CMD3 -> CMD7 -> CMD55B -> ACMD6 -> DONE; any failure -> ERR.
REQ-018 Command states: CMD8 idx 8 arg 0x000001AA; CMD55 idx 55 arg 0; ACMD41 idx 41 arg 0x40FF8000; CMD2 idx 2 arg 0; CMD3 idx 3 arg 0; CMD7 idx 7 arg {orca,16'h0}; CMD55B idx 55 arg {orca,16'h0}; ACMD6 idx 6 arg 0x00000002.
REQ-019 Handshake: on entering a command state, ostart rises the next cycle with index/arg valid; ostart, ocmd_index, ocmd_arg held stable until the cycle idone is sampled high; ostart low the following cycle and at least one cycle before the next command.
REQ-020 idone while ostart is low is ignored.
REQ-021 PWRUP counts exactly PWRUP_CYC cycles with ostart low, then enters CMD8.
REQ-022 CMD8 passes if iresp[11:0]==12'h1AA, else ERR.
REQ-023 CMD55/CMD55B pass if iresp[5]==1 and iresp[31],[30],[22],[19] all 0, else ERR; CMD7 and ACMD6 use the same status-bit check without bit 5.
REQ-024 ACMD41: iresp[31]==1 -> latch occs=iresp[30], go CMD2; iresp[31]==0 -> increment attempt counter, back to CMD55; attempt counter reaching RETRIES -> ERR.
REQ-025 CMD2 response content ignored; GAP waits GAP_CYC cycles (remaining R2 bits pass) then CMD3.
REQ-026 CMD3 latches orca=iresp[31:16]; no status check.
REQ-027 Timeout counter restarts on each ostart rise; TIMEOUT cycles without idone -> ERR, ostart deasserted.
REQ-028 DONE and ERR are terminal; odone/oerr held high; istart ignored; only reset exits.
REQ-029 odone and oerr never high simultaneously.

Reset
REQ-030 Asynchronous irst forces IDLE; ostart, odone, oerr, occs 0; ocmd_index 0; ocmd_arg 0; orca 0; all counters 0.
REQ-031 Reset mid-command drops ostart within the reset assertion, no further handshake completion is expected.

Structure
REQ-032 Shared SD package holds command index constants (CMD2/3/6/7/8/41/55), CMD8 check pattern, ACMD41 argument, R1 error-bit positions.
REQ-033 Single module; the shared cycle counter (PWRUP/GAP/TIMEOUT) is internal, no sub-module.

Verification
REQ-034 Bench uses a behavioural cmd_driver model answering each ostart with idone after 100 cycles and scripted iresp.
REQ-035 Happy path: istart=1; CMD8 resp 0x000001AA, ACMD41 resp 0xC0FF8000 first try, CMD3 resp 0x12340500 -> order 8,55,41,2,3,7,55,6; CMD7 arg 0x12340000; orca=0x1234, occs=1, odone=1.
REQ-036 ACMD41 busy: resp 0x00FF8000 twice then 0x80FF8000 -> three CMD55/ACMD41 pairs, occs=0, odone=1.
REQ-037 CMD8 mismatch: resp 0x000001AB -> oerr=1, no further ostart.
REQ-038 Timeout: model never asserts idone on CMD3 -> oerr=1 exactly TIMEOUT cycles after ostart rise.
REQ-039 Reset mid-ACMD41: irst pulse -> outputs at reset values immediately; new istart reruns from PWRUP.
